// File: rtl/jt12_slotmon.sv
// ---------------------------------------------------------------------------
// jt12_slotmon
// Monitor for time-multiplexed operator/channel streams in the JT12 pipeline
// (for example the 24-slot phase or envelope buses). It follows slot
// position from a frame sync and applies a fixed pipeline offset. It taps one
// selectable slot and reduces a masked set of slots with AND and OR over each
// complete frame. It also flags a sync that arrives off-position.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   cen        clock enable; all state advances only when cen=1
//   sync       marks position 0 on this enabled cycle
//   din        stream data (W bits)
//   mask       bit i=1 includes slot i in the reductions
//   sel        slot number to tap
//   clr        clears sync_err
//   tap        last captured value of slot sel
//   alland     AND of the masked slots over the last complete frame
//   allor      OR of the masked slots over the last complete frame
//   frame_done one-clk pulse when alland/allor update
//   locked     a sync has been received since reset
//   sync_err   sticky: a sync arrived off-position while locked
// ---------------------------------------------------------------------------
module jt12_slotmon #(
    parameter int W     = 10,
    parameter int SLOTS = 24,
    parameter int POS0  = 7,
    parameter int SW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             sync,
    input  logic [W-1:0]     din,
    input  logic [SLOTS-1:0] mask,
    input  logic [SW-1:0]    sel,
    input  logic             clr,
    output logic [W-1:0]     tap,
    output logic [W-1:0]     alland,
    output logic [W-1:0]     allor,
    output logic             frame_done,
    output logic             locked,
    output logic             sync_err
);

    // Illegal parameter sets stop elaboration.
    generate
        if (SLOTS < 2) begin : g_bad_slots
            $error("jt12_slotmon: SLOTS must be at least 2");
        end
        if (POS0 >= SLOTS) begin : g_bad_pos0
            $error("jt12_slotmon: POS0 must be smaller than SLOTS");
        end
        if ((64'd1 << SW) < 64'(SLOTS)) begin : g_bad_sw
            $error("jt12_slotmon: SW too narrow for SLOTS");
        end
    endgenerate

    localparam logic [SW-1:0] ZERO = {SW{1'b0}};
    localparam logic [SW-1:0] ONE  = SW'(1);
    localparam logic [SW-1:0] LAST = SW'(SLOTS - 1);
    localparam logic [SW-1:0] P0   = SW'(POS0);
    // Added to wrap a position below POS0 back into 0..SLOTS-1.
    localparam logic [SW-1:0] BACK = SW'(SLOTS - POS0);
    localparam logic [W-1:0]  ONES = {W{1'b1}};
    localparam logic [W-1:0]  NONE = {W{1'b0}};

    logic [SW-1:0]    cnt_r;
    logic             locked_r;
    logic             primed_r;
    logic             sync_err_r;
    logic [W-1:0]     acc_and_r;
    logic [W-1:0]     acc_or_r;
    logic [W-1:0]     tap_r;
    logic [W-1:0]     alland_r;
    logic [W-1:0]     allor_r;
    logic             frame_done_r;

    logic [SW-1:0]    pos_s;
    logic [SW-1:0]    cnt_nxt_s;
    logic [SW-1:0]    dslot_s;
    logic [SLOTS-1:0] mask_sh_s;
    logic             mask_bit_s;
    logic             bad_sync_s;
    logic             active_s;
    logic             first_s;
    logic             accum_s;
    logic             done_s;
    logic             tap_hit_s;
    logic [W-1:0]     base_and_s;
    logic [W-1:0]     base_or_s;
    logic [W-1:0]     next_and_s;
    logic [W-1:0]     next_or_s;

    // Slot decoding, accumulator update values and event strobes.
    always_comb begin
        pos_s      = (sync == 1'b1) ? ZERO : cnt_r;
        cnt_nxt_s  = (pos_s == LAST) ? ZERO : (pos_s + ONE);
        dslot_s    = (pos_s >= P0) ? (pos_s - P0) : (pos_s + BACK);
        mask_sh_s  = mask >> dslot_s;
        mask_bit_s = mask_sh_s[0];
        // A sync away from position 0 after lock realigns and drops the frame.
        bad_sync_s = cen & sync & locked_r & (cnt_r != ZERO);
        active_s   = cen & locked_r & ~bad_sync_s;
        first_s    = active_s & (dslot_s == ZERO);
        accum_s    = first_s | (active_s & primed_r);
        done_s     = active_s & primed_r & (dslot_s == LAST);
        tap_hit_s  = cen & locked_r & (dslot_s == sel);
        // Slot 0 starts from the identity values before being applied.
        base_and_s = (first_s == 1'b1) ? ONES : acc_and_r;
        base_or_s  = (first_s == 1'b1) ? NONE : acc_or_r;
        next_and_s = (mask_bit_s == 1'b1) ? (base_and_s & din) : base_and_s;
        next_or_s  = (mask_bit_s == 1'b1) ? (base_or_s | din) : base_or_s;
    end

    // Position counter and lock flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= ZERO;
            locked_r <= 1'b0;
        end else if (cen) begin
            cnt_r    <= cnt_nxt_s;
            locked_r <= locked_r | sync;
        end else begin
            cnt_r    <= cnt_r;
            locked_r <= locked_r;
        end
    end

    // Frame-in-progress flag: set at data slot 0, dropped on a misaligned sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed_r <= 1'b0;
        end else if (bad_sync_s) begin
            primed_r <= 1'b0;
        end else if (first_s) begin
            primed_r <= 1'b1;
        end else begin
            primed_r <= primed_r;
        end
    end

    // Running AND/OR accumulators for the frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_and_r <= NONE;
            acc_or_r  <= NONE;
        end else if (accum_s) begin
            acc_and_r <= next_and_s;
            acc_or_r  <= next_or_s;
        end else begin
            acc_and_r <= acc_and_r;
            acc_or_r  <= acc_or_r;
        end
    end

    // Frame results and the completion pulse; the pulse is re-evaluated every
    // clk so it never stretches when cen is low on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alland_r     <= NONE;
            allor_r      <= NONE;
            frame_done_r <= 1'b0;
        end else if (done_s) begin
            alland_r     <= next_and_s;
            allor_r      <= next_or_s;
            frame_done_r <= 1'b1;
        end else begin
            alland_r     <= alland_r;
            allor_r      <= allor_r;
            frame_done_r <= 1'b0;
        end
    end

    // Sticky misalignment flag; a new error wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err_r <= 1'b0;
        end else if (bad_sync_s) begin
            sync_err_r <= 1'b1;
        end else if (cen & clr) begin
            sync_err_r <= 1'b0;
        end else begin
            sync_err_r <= sync_err_r;
        end
    end

    // Tap capture; a sel beyond the last slot never matches, so tap holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_r <= NONE;
        end else if (tap_hit_s) begin
            tap_r <= din;
        end else begin
            tap_r <= tap_r;
        end
    end

    assign tap        = tap_r;
    assign alland     = alland_r;
    assign allor      = allor_r;
    assign frame_done = frame_done_r;
    assign locked     = locked_r;
    assign sync_err   = sync_err_r;

endmodule

// File: tb/tb_jt12_slotmon.sv
// ---------------------------------------------------------------------------
// Directed testbench for jt12_slotmon with default parameters.
// The bench keeps its own notion of the stream position (bpos) and drives
// din for the data slot that position carries, so all expected values come
// from the stimulus itself.
// ---------------------------------------------------------------------------
module tb_jt12_slotmon;

    localparam int W     = 10;
    localparam int SLOTS = 24;
    localparam int POS0  = 7;
    localparam int SW    = 5;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             cen   = 1'b0;
    logic             sync  = 1'b0;
    logic             clr   = 1'b0;
    logic [W-1:0]     din   = '0;
    logic [SLOTS-1:0] mask  = '0;
    logic [SW-1:0]    sel   = '0;
    logic [W-1:0]     tap;
    logic [W-1:0]     alland;
    logic [W-1:0]     allor;
    logic             frame_done;
    logic             locked;
    logic             sync_err;

    int n_checks   = 0;
    int n_fail     = 0;
    int cur        = 0;
    int bpos       = 0;
    int done_cnt   = 0;
    int first_done = -1;
    int last_done  = -1;
    int wide_cnt   = 0;
    int last_sync  = 0;
    int bad_t      = 0;
    int t0         = 0;
    bit prev_done  = 1'b0;
    bit rnd_mode   = 1'b0;
    logic [W-1:0] sdata    [SLOTS];
    logic [W-1:0] last_val [SLOTS];
    logic [W-1:0] exp_hold;

    jt12_slotmon #(.W(W), .SLOTS(SLOTS), .POS0(POS0), .SW(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .sync       (sync),
        .din        (din),
        .mask       (mask),
        .sel        (sel),
        .clr        (clr),
        .tap        (tap),
        .alland     (alland),
        .allor      (allor),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clk; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cur++;
        if (frame_done === 1'b1) begin
            done_cnt++;
            if (done_cnt == 1) first_done = cur;
            last_done = cur;
            if (prev_done) wide_cnt++;
        end
        prev_done = (frame_done === 1'b1);
    endtask

    task automatic clear_done();
        done_cnt   = 0;
        first_done = -1;
        last_done  = -1;
        wide_cnt   = 0;
    endtask

    task automatic drive_pos(input bit sync_en);
        int ds;
        ds   = (bpos + SLOTS - POS0) % SLOTS;
        sync = sync_en && (bpos == 0);
        if (rnd_mode) din = W'($urandom_range(0, 1023));
        else          din = sdata[ds];
        last_val[ds] = din;
        if (sync) last_sync = cur;
    endtask

    task automatic run(input int n, input bit sync_en);
        for (int i = 0; i < n; i++) begin
            drive_pos(sync_en);
            tick();
            bpos = (bpos + 1) % SLOTS;
        end
        sync = 1'b0;
    endtask

    task automatic run_to(input int p, input bit sync_en);
        run((p - bpos + SLOTS) % SLOTS, sync_en);
    endtask

    // Each position held for two clks, enabled on the first only.
    task automatic run_half(input int n);
        for (int i = 0; i < n; i++) begin
            drive_pos(1'b1);
            cen = 1'b1;
            tick();
            cen = 1'b0;
            tick();
            bpos = (bpos + 1) % SLOTS;
        end
        sync = 1'b0;
        cen  = 1'b1;
    endtask

    // Sync at a non-zero position: the position becomes 0, data slot SLOTS-POS0.
    task automatic bad_tick(input bit with_clr);
        sync = 1'b1;
        clr  = with_clr;
        din  = sdata[SLOTS - POS0];
        last_val[SLOTS - POS0] = din;
        bad_t = cur;
        tick();
        sync = 1'b0;
        clr  = 1'b0;
        bpos = 1;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < SLOTS; i++) sdata[i] = W'(3 * i);
    endtask

    initial begin
        for (int i = 0; i < SLOTS; i++) last_val[i] = '0;
        set_ramp();

        // Reset state
        cen = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tap", 32'(tap), 32'h0);
        chk("rst_alland", 32'(alland), 32'h0);
        chk("rst_allor", 32'(allor), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_sync_err", 32'(sync_err), 32'h0);
        rst_n = 1'b1;
        bpos  = 0;

        // Ramp data, periodic sync, sel=5
        sel  = 5'd5;
        mask = {SLOTS{1'b1}};
        run(3, 1'b0);
        chk("unlocked_before_sync", 32'(locked), 32'h0);
        run_to(0, 1'b0);
        clear_done();
        run(1, 1'b1);
        t0 = last_sync;
        chk("locked_after_sync", 32'(locked), 32'h1);
        run(79, 1'b1);
        chk("first_done_latency", 32'(first_done - t0), 32'd31);
        chk("done_count", 32'(done_cnt), 32'd3);
        chk("done_period", 32'(last_done - first_done), 32'd48);
        chk("ramp_tap", 32'(tap), 32'd15);
        chk("ramp_alland", 32'(alland), 32'h000);
        chk("ramp_allor", 32'(allor), 32'h07F);
        chk("ramp_sync_err", 32'(sync_err), 32'h0);

        // Slot 0 = 0x155, others 0x0F0, three masks
        for (int i = 0; i < SLOTS; i++) sdata[i] = 10'h0F0;
        sdata[0] = 10'h155;
        mask = ~24'h000001;
        run(48, 1'b1);
        chk("mask_no0_alland", 32'(alland), 32'h0F0);
        chk("mask_no0_allor", 32'(allor), 32'h0F0);
        mask = 24'hFFFFFF;
        run(48, 1'b1);
        chk("mask_all_alland", 32'(alland), 32'h050);
        chk("mask_all_allor", 32'(allor), 32'h1F5);
        mask = 24'h000000;
        run(48, 1'b1);
        chk("mask_none_alland", 32'(alland), 32'h3FF);
        chk("mask_none_allor", 32'(allor), 32'h000);
        chk("pattern_sync_err", 32'(sync_err), 32'h0);

        // Misaligned sync at position 10
        mask = 24'hFFFFFF;
        run_to(10, 1'b1);
        clear_done();
        bad_tick(1'b0);
        chk("bad_sync_err_set", 32'(sync_err), 32'h1);
        run(31, 1'b1);
        chk("bad_done_count", 32'(done_cnt), 32'd1);
        chk("bad_done_latency", 32'(first_done - bad_t), 32'd31);
        chk("bad_alland", 32'(alland), 32'h050);
        chk("bad_allor", 32'(allor), 32'h1F5);
        chk("bad_sync_err_sticky", 32'(sync_err), 32'h1);
        clr = 1'b1;
        run(1, 1'b1);
        clr = 1'b0;
        chk("clr_sync_err", 32'(sync_err), 32'h0);
        run_to(10, 1'b1);
        bad_tick(1'b1);
        chk("set_wins_over_clr", 32'(sync_err), 32'h1);

        // cen on every other clk
        set_ramp();
        run_half(48);
        clear_done();
        run_half(48);
        chk("half_done_count", 32'(done_cnt), 32'd2);
        chk("half_done_period", 32'(last_done - first_done), 32'd48);
        chk("half_done_width", 32'(wide_cnt), 32'd0);
        chk("half_tap", 32'(tap), 32'd15);
        chk("half_alland", 32'(alland), 32'h000);
        chk("half_allor", 32'(allor), 32'h07F);

        // Asynchronous reset in mid-frame
        run_to(12, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_tap", 32'(tap), 32'h0);
        chk("async_alland", 32'(alland), 32'h0);
        chk("async_allor", 32'(allor), 32'h0);
        chk("async_frame_done", 32'(frame_done), 32'h0);
        chk("async_locked", 32'(locked), 32'h0);
        chk("async_sync_err", 32'(sync_err), 32'h0);
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        bpos  = 0;
        clear_done();
        run(60, 1'b0);
        chk("post_rst_locked", 32'(locked), 32'h0);
        chk("post_rst_no_done", 32'(done_cnt), 32'd0);
        run_to(0, 1'b0);
        clear_done();
        run(1, 1'b1);
        t0 = last_sync;
        run(31, 1'b1);
        chk("post_rst_done_count", 32'(done_cnt), 32'd1);
        chk("post_rst_done_latency", 32'(first_done - t0), 32'd31);
        chk("post_rst_allor", 32'(allor), 32'h07F);

        // sel sweep over a random stream
        rnd_mode = 1'b1;
        for (int s = 0; s < SLOTS; s++) begin
            sel = SW'(s);
            run(24, 1'b1);
            chk($sformatf("sweep_tap_%0d", s), 32'(tap), 32'(last_val[s]));
        end
        exp_hold = last_val[SLOTS - 1];
        sel = 5'd30;
        run(30, 1'b1);
        chk("sel30_hold", 32'(tap), 32'(exp_hold));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
